// File: rtl/sobel_edge_3x3_if.sv
// Interface bundle for sobel_edge_3x3.
// Purpose: carries the 3x3 window stream from the matrix stage (with its
// delayed vsync/href and the threshold request) into the Sobel core. It also
// carries the gradient/edge outputs and per-frame edge statistics back out.
// Signals:
//   matrix_frame_vsync/href   frame/line valid from matrix stage
//   matrix_p11..matrix_p33    3x3 window, row 1 top, column 1 left
//   thresh                    edge threshold request (sampled per frame)
//   post_frame_vsync/href     syncs delayed by the pipeline (3 cycles)
//   post_img_grad             saturated |Gx|+|Gy|
//   post_img_Bit              binary edge pixel
//   edge_count                edge pixels of the last completed frame
//   frame_done                one-cycle pulse when edge_count updates
// Modports: master drives the window stream, slave is the Sobel core.
interface sobel_edge_3x3_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic                  matrix_frame_vsync;
  logic                  matrix_frame_href;
  logic [DATA_WIDTH-1:0] matrix_p11;
  logic [DATA_WIDTH-1:0] matrix_p12;
  logic [DATA_WIDTH-1:0] matrix_p13;
  logic [DATA_WIDTH-1:0] matrix_p21;
  logic [DATA_WIDTH-1:0] matrix_p22;
  logic [DATA_WIDTH-1:0] matrix_p23;
  logic [DATA_WIDTH-1:0] matrix_p31;
  logic [DATA_WIDTH-1:0] matrix_p32;
  logic [DATA_WIDTH-1:0] matrix_p33;
  logic [DATA_WIDTH+2:0] thresh;

  logic                  post_frame_vsync;
  logic                  post_frame_href;
  logic [DATA_WIDTH-1:0] post_img_grad;
  logic                  post_img_Bit;
  logic [CNT_WIDTH-1:0]  edge_count;
  logic                  frame_done;

  modport master (
    output matrix_frame_vsync, matrix_frame_href,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33,
    output thresh,
    input  post_frame_vsync, post_frame_href,
    input  post_img_grad, post_img_Bit,
    input  edge_count, frame_done
  );

  modport slave (
    input  matrix_frame_vsync, matrix_frame_href,
    input  matrix_p11, matrix_p12, matrix_p13,
    input  matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33,
    input  thresh,
    output post_frame_vsync, post_frame_href,
    output post_img_grad, post_img_Bit,
    output edge_count, frame_done
  );
endinterface

// File: rtl/sobel_edge_3x3.sv
// Pipelined 3x3 Sobel edge detector.
// Purpose: each cycle takes one 3x3 neighbourhood and computes |Gx|+|Gy| in
// three register stages. It emits a saturated gradient and a binary edge
// pixel against a per-frame latched threshold, and counts edge pixels per frame.
// Ports:
//   clk   pixel clock
//   rst   synchronous active-high reset
//   bus   sobel_edge_3x3_if.slave (window stream in, gradient/edge/stats out)
module sobel_edge_3x3 #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned THRESH_INIT = 80,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic              clk,
  input  logic              rst,
  sobel_edge_3x3_if.slave   bus
);

  localparam int unsigned N  = DATA_WIDTH;
  localparam int unsigned SW = N + 2;     // weighted column/row sum width
  localparam int unsigned MW = N + 3;     // |Gx|+|Gy| width
  localparam int unsigned CW = CNT_WIDTH;

  localparam logic [MW-1:0] PIX_MAX   = {3'b000, {N{1'b1}}};
  localparam logic [MW-1:0] THR_RESET = MW'(THRESH_INIT);

  // ---------------------------------------------------------------------------
  // Stage 1: weighted sums of the outer columns and rows
  // ---------------------------------------------------------------------------
  logic [SW-1:0] xp_d, xn_d, yp_d, yn_d;
  logic [SW-1:0] xp_q, xn_q, yp_q, yn_q;

  always_comb begin
    xp_d = SW'(bus.matrix_p13) + (SW'(bus.matrix_p23) << 1) + SW'(bus.matrix_p33);
    xn_d = SW'(bus.matrix_p11) + (SW'(bus.matrix_p21) << 1) + SW'(bus.matrix_p31);
    yp_d = SW'(bus.matrix_p31) + (SW'(bus.matrix_p32) << 1) + SW'(bus.matrix_p33);
    yn_d = SW'(bus.matrix_p11) + (SW'(bus.matrix_p12) << 1) + SW'(bus.matrix_p13);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xp_q <= '0;
      xn_q <= '0;
      yp_q <= '0;
      yn_q <= '0;
    end else begin
      xp_q <= xp_d;
      xn_q <= xn_d;
      yp_q <= yp_d;
      yn_q <= yn_d;
    end
  end

  // The centre tap carries no Sobel weight.
  logic unused_p22;
  assign unused_p22 = ^bus.matrix_p22;

  // ---------------------------------------------------------------------------
  // Stage 2: absolute differences, subtracting the smaller from the larger
  // so no sign bit is ever needed
  // ---------------------------------------------------------------------------
  logic [SW-1:0] gx_d, gy_d;
  logic [SW-1:0] gx_q, gy_q;

  always_comb begin
    gx_d = (xp_q >= xn_q) ? (xp_q - xn_q) : (xn_q - xp_q);
    gy_d = (yp_q >= yn_q) ? (yp_q - yn_q) : (yn_q - yp_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gx_q <= '0;
      gy_q <= '0;
    end else begin
      gx_q <= gx_d;
      gy_q <= gy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sync delay lines. qv_q is vsync qualified by a frame whose rising edge was
  // seen after reset; it gates counting and frame_done so a frame cut by
  // reset is discarded.
  // ---------------------------------------------------------------------------
  logic [2:0] vs_d, vs_q;
  logic [2:0] hr_d, hr_q;
  logic [2:0] qv_d, qv_q;

  logic       vsync_in_q;
  logic       low_seen_d, low_seen_q;
  logic       frame_act_d, frame_act_q;
  logic       vsync_rise_c;
  logic       qv_in_c;

  // Rising edge only counts once vsync has been seen low since reset.
  assign vsync_rise_c = bus.matrix_frame_vsync & ~vsync_in_q & low_seen_q;
  assign qv_in_c      = bus.matrix_frame_vsync & (vsync_rise_c | frame_act_q);

  always_comb begin
    vs_d        = {vs_q[1:0], bus.matrix_frame_vsync};
    hr_d        = {hr_q[1:0], bus.matrix_frame_href};
    qv_d        = {qv_q[1:0], qv_in_c};
    low_seen_d  = low_seen_q | ~bus.matrix_frame_vsync;
    frame_act_d = frame_act_q;
    if (!bus.matrix_frame_vsync) begin
      frame_act_d = 1'b0;
    end else if (vsync_rise_c) begin
      frame_act_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q        <= '0;
      hr_q        <= '0;
      qv_q        <= '0;
      vsync_in_q  <= 1'b0;
      low_seen_q  <= 1'b0;
      frame_act_q <= 1'b0;
    end else begin
      vs_q        <= vs_d;
      hr_q        <= hr_d;
      qv_q        <= qv_d;
      vsync_in_q  <= bus.matrix_frame_vsync;
      low_seen_q  <= low_seen_d;
      frame_act_q <= frame_act_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Threshold latch: loaded on the input vsync rising edge. The inter-frame
  // gap keeps it stable while the previous frame drains through stage 3.
  // ---------------------------------------------------------------------------
  logic [MW-1:0] thr_d, thr_q;

  always_comb begin
    thr_d = thr_q;
    if (vsync_rise_c) begin
      thr_d = bus.thresh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q <= THR_RESET;
    end else begin
      thr_q <= thr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: magnitude, saturation, threshold compare; gated by the href that
  // lands on the outputs together with this data
  // ---------------------------------------------------------------------------
  logic [MW-1:0] mag_c;
  logic [N-1:0]  grad_d, grad_q;
  logic          bit_d, bit_q;

  always_comb begin
    mag_c  = MW'(gx_q) + MW'(gy_q);
    grad_d = '0;
    bit_d  = 1'b0;
    if (hr_q[1]) begin
      grad_d = (mag_c > PIX_MAX) ? {N{1'b1}} : N'(mag_c);
      bit_d  = (mag_c > thr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grad_q <= '0;
      bit_q  <= 1'b0;
    end else begin
      grad_q <= grad_d;
      bit_q  <= bit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge counter. frame_end fires on the last output cycle with vsync high, so
  // the registered frame_done lands on the first cycle post_frame_vsync is low
  // and the pixel on that last cycle is still folded into edge_count.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_d, cnt_q;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] edge_count_d, edge_count_q;
  logic          frame_done_d, frame_done_q;
  logic          qual_c;
  logic          frame_end_c;

  assign qual_c      = hr_q[2] & bit_q & qv_q[2];
  assign frame_end_c = qv_q[2] & ~qv_q[1];

  always_comb begin
    cnt_d        = cnt_q;
    edge_count_d = edge_count_q;
    frame_done_d = 1'b0;
    cnt_inc      = (&cnt_q) ? cnt_q : (cnt_q + CW'(1));
    if (frame_end_c) begin
      edge_count_d = qual_c ? cnt_inc : cnt_q;
      cnt_d        = '0;
      frame_done_d = 1'b1;
    end else if (qual_c) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      edge_count_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      edge_count_q <= edge_count_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Outputs
  assign bus.post_frame_vsync = vs_q[2];
  assign bus.post_frame_href  = hr_q[2];
  assign bus.post_img_grad    = grad_q;
  assign bus.post_img_Bit     = bit_q;
  assign bus.edge_count       = edge_count_q;
  assign bus.frame_done       = frame_done_q;

endmodule
